// File: rtl/demux_2x16_reg.sv
// Registered 1-to-4 demultiplexer: a word and a 2-bit key are accepted over valid/ready and parked in one of four single-entry slots.
// Define DEMUX_COUNT_EN to add saturating per-channel delivery counters on out_cnt.
module demux_2x16_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         key,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [4*CNT_W-1:0] out_cnt
`endif
);

`ifdef DEMUX_COUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    logic       accept_p0;
    logic [3:0] vld_p1;

    // Stage p0: handshake decode; only the addressed slot can stall the producer
    assign in_ready  = !vld_p1[key] || out_ready[key];
    assign accept_p0 = in_valid && in_ready;
    assign out_valid = vld_p1;

    for (genvar i = 0; i < 4; i++) begin : g_slot
        logic             sel_p0;
        logic             vld_p1_q;
        logic [WIDTH-1:0] data_p1_q;

        assign sel_p0    = accept_p0 && (key == 2'(i));
        assign vld_p1[i] = vld_p1_q;
        assign out_data[i*WIDTH +: WIDTH] = data_p1_q;

        // Stage p1: slot register; a refill in the drain cycle keeps the slot full
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_p1_q  <= 1'b0;
                data_p1_q <= '0;
            end else if (sel_p0) begin
                vld_p1_q  <= 1'b1;
                data_p1_q <= in_data;
            end else if (out_ready[i]) begin
                vld_p1_q  <= 1'b0;
            end
        end

`ifdef DEMUX_COUNT_EN
        logic [CNT_W-1:0] cnt_p1_q;

        assign out_cnt[i*CNT_W +: CNT_W] = cnt_p1_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_p1_q <= '0;
            end else if (vld_p1_q && out_ready[i]) begin
                cnt_p1_q <= sat_inc(cnt_p1_q);
            end
        end
`endif
    end

endmodule
